// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux between four requesters.
// It has a bounded hold counter so that no requester keeps the mux while others wait.
module mux_select_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       addr0,
    output logic       addr1,
    output logic       busy
);

    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_last;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_winner;
    logic [1:0]    w_idx;
    logic          w_found;
    logic          w_owner_req;
    logic          w_others;
    logic          w_take;
    logic          w_release;

    // The scan starts at last+1 and wraps to last itself (k=4).
    // So in GRANT the owner is picked only when it is the sole requester.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_owner_req = req[r_last];
        w_others    = |(req & ~(4'b0001 << r_last));
        w_take      = 1'b0;
        w_release   = 1'b0;
        if (r_state == ST_IDLE) begin
            w_take = |req;
        end else if (!w_owner_req) begin
            w_take    = w_others;
            w_release = !w_others;
        end else begin
            w_take = w_others && (r_cnt == HOLD_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            grant   <= '0;
            addr0   <= 1'b0;
            addr1   <= 1'b0;
            busy    <= 1'b0;
        end else if (w_take) begin
            r_state <= ST_GRANT;
            r_last  <= w_winner;
            r_cnt   <= '0;
            grant   <= 4'b0001 << w_winner;
            addr0   <= w_winner[0];
            addr1   <= w_winner[1];
            busy    <= 1'b1;
        end else if (w_release) begin
            r_state <= ST_IDLE;
            grant   <= '0;
            busy    <= 1'b0;
        end else if (r_state == ST_GRANT && r_cnt != HOLD_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Testbench for mux_select_arbiter. It runs directed steps and then random traffic.
// Results are compared against a reference model that counts grant tenure in whole cycles.
module tb_mux_select_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       addr0;
    logic       addr1;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    int m_addr  = 0;

    mux_select_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant),
        .addr0 (addr0),
        .addr1 (addr1),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_give(input int w);
        m_owner = w;
        m_last  = w;
        m_held  = 1;
        m_addr  = w;
    endtask

    task automatic model_edge(input logic [3:0] r, input bit rst);
        int  win;
        bit  others;
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_held  = 0;
            m_addr  = 0;
            return;
        end
        win = search(r, m_last);
        if (m_owner < 0) begin
            if (r != 4'b0000) model_give(win);
        end else begin
            others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (!r[m_owner]) begin
                if (others) model_give(win);
                else        m_owner = -1;
            end else if (others && m_held >= int'(MAX_HOLD)) begin
                model_give(win);
            end else begin
                m_held++;
            end
        end
    endtask

    // Apply one vector, clock it in, then compare against the model 1 time unit after the edge.
    task automatic cycle(input logic [3:0] r, input bit rst);
        logic [3:0] exp_grant;
        req   = r;
        reset = rst;
        @(posedge clk);
        model_edge(r, rst);
        #1;
        n_vec++;
        exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        chk("grant", {28'b0, grant}, {28'b0, exp_grant});
        chk("busy", {31'b0, busy}, {31'b0, m_owner >= 0});
        chk("addr", {30'b0, addr1, addr0}, m_addr);
        chk("inv_onehot0", {31'b0, $onehot0(grant)}, 32'd1);
        chk("inv_busy_or", {31'b0, busy}, {31'b0, |grant});
        if (busy) chk("inv_addr_grant", {31'b0, grant[{addr1, addr0}]}, 32'd1);
    endtask

    initial begin
        logic [3:0] r;
        reset = 1'b1;
        req   = 4'b0000;

        // Check the values right after reset.
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("rst_grant", {28'b0, grant}, 32'h0);
        chk("rst_addr", {30'b0, addr1, addr0}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);

        // A single request is granted on the next edge, then released.
        cycle(4'b0001, 1'b0);
        chk("tp1_grant", {28'b0, grant}, 32'h1);
        chk("tp1_busy", {31'b0, busy}, 32'h1);
        cycle(4'b0000, 1'b0);
        chk("tp1_rel_grant", {28'b0, grant}, 32'h0);
        chk("tp1_rel_addr", {30'b0, addr1, addr0}, 32'h0);

        // With all four requesting, each requester holds for MAX_HOLD cycles in turn.
        cycle(4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(4'b1111, 1'b0);
            chk("tp2_rot_grant", {28'b0, grant}, 32'h1 << ((i / 4) % 4));
            chk("tp2_rot_addr", {30'b0, addr1, addr0}, (i / 4) % 4);
        end

        // A sole requester holds the grant with no forced rotation.
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0100, 1'b0);
            chk("tp3_sole_grant", {28'b0, grant}, 32'h4);
            chk("tp3_sole_addr", {30'b0, addr1, addr0}, 32'd2);
        end

        // Owner handoff happens with no idle bubble.
        cycle(4'b0010, 1'b0);
        chk("tp4_h1_grant", {28'b0, grant}, 32'h2);
        cycle(4'b1000, 1'b0);
        chk("tp4_h2_grant", {28'b0, grant}, 32'h8);
        chk("tp4_h2_addr", {30'b0, addr1, addr0}, 32'd3);
        chk("tp4_h2_busy", {31'b0, busy}, 32'h1);

        // After a release, the search resumes from last+1.
        cycle(4'b0100, 1'b0);
        chk("tp5_own2", {28'b0, grant}, 32'h4);
        cycle(4'b1011, 1'b0);
        chk("tp5_fair", {28'b0, grant}, 32'h8);

        // Reset during a grant.
        cycle(4'b0100, 1'b0);
        chk("tp6_pre", {28'b0, grant}, 32'h4);
        cycle(4'b1010, 1'b1);
        chk("tp6_rst_grant", {28'b0, grant}, 32'h0);
        chk("tp6_rst_busy", {31'b0, busy}, 32'h0);
        chk("tp6_rst_addr", {30'b0, addr1, addr0}, 32'h0);
        cycle(4'b1010, 1'b0);
        chk("tp6_post", {28'b0, grant}, 32'h2);

        // Random traffic with occasional resets, checked against the model.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(r, $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
# mux_select_arbiter

Round-robin arbiter that shares one 4:1 multiplexer between four requesters. Samples a 4-bit request vector each clock, grants exactly one requester at a time, and drives the multiplexer's `addr0`/`addr1` select lines to route the granted input to the shared output. A bounded hold counter stops any one requester from monopolising the mux while others wait.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one requester while another is waiting. Legal range is 1..256.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  in  4  request vector. `req[i]` high means requester i wants mux input `in<i>` routed to the output.
- `grant`  out  4  one-hot grant. All zero when idle. Registered.
- `addr0`  out  1  mux select LSB, equal to bit 0 of the granted index. Registered.
- `addr1`  out  1  mux select MSB, equal to bit 1 of the granted index. Registered.
- `busy`  out  1  high whenever `grant` is nonzero. Registered.

## Operation
- Select encoding matches the mux:
  - index 0 gives `addr1`,`addr0` = 0,0.
  - index 1 gives 0,1.
  - index 2 gives 1,0.
  - index 3 gives 1,1.
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 2-bit `last` pointer holding the most recently granted index.
  - hold counter of width clog2(`MAX_HOLD`), minimum 1 bit.
- Round-robin search: candidates are scanned from `last`+1 upward, mod 4. The first index with `req` high wins.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise grant the search winner. Go to GRANT, clear the counter, set `last` to the winner.
- GRANT, with owner o. Evaluated each edge, first match applies:
  - `req[o]`=0 and other requests pending: switch directly to the search winner with no idle bubble. Clear the counter and update `last`.
  - `req[o]`=0 and no other requests pending: go to IDLE. `grant` becomes 0 and `busy` becomes 0.
  - `req[o]`=1, other requests pending, counter == `MAX_HOLD`-1: forced rotation to the search winner, which is never o. Clear the counter and update `last`.
  - `req[o]`=1, otherwise: keep the grant. Counter increments and saturates at `MAX_HOLD`-1.
- With a sole requester, the grant is held indefinitely and no forced rotation occurs.
- `addr0`/`addr1` keep their last granted value while in IDLE. The mux output in IDLE is don't-care to consumers, who must qualify it with `busy`.
- Invariants checked by the bench:
  - `grant` is always one-hot or zero.
  - `busy` == |`grant`.
  - When `busy`=1, `grant[{addr1,addr0}]`=1.

## Timing
- Reset values: `grant`=0000, `addr0`=0, `addr1`=0, `busy`=0, state IDLE, `last`=3 (so the first search starts at index 0), counter=0.
- Reset mid-grant: the grant is dropped on that same edge and all reset values apply. Reset takes priority over all requests.
- Latency: a `req` change sampled at edge N shows up on `grant`, `addr*` and `busy` after edge N.
- The grant is visible for the whole cycle following that edge.
- Requester hold protocol:
  - A requester holds `req` high for as long as it needs the mux.
  - Deasserting `req` releases the grant at the next edge.
  - `req` is not required to stay high until granted. A dropped request is simply not considered.
- With all four requesting continuously, each requester gets exactly `MAX_HOLD` consecutive cycles. Order is 0,1,2,3,0,...
- `MAX_HOLD`=1: the grant rotates every cycle while two or more requesters are active.
- Simultaneous owner release and new request: resolved in a single edge, with no IDLE cycle.

## Test plan
- Reset, then `req`=0001: after one edge, `grant`=0001, `addr1`,`addr0`=0,0, `busy`=1. Set `req`=0000: after the next edge, `grant`=0000, `busy`=0, addr stays 0,0.
- `MAX_HOLD`=4, `req`=1111 held for 20 cycles: `grant` is 0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001. `addr` tracks 00, 01, 10, 11.
- `req`=0100 alone for 10 cycles: `grant`=0100 and `addr`=1,0 for all 10 cycles. No rotation and no bubble.
- Owner handoff: grant at 0010, then in one cycle `req` changes from 0010 to 1000. The next edge gives `grant`=1000 and `addr`=1,1. `busy` stays 1 throughout.
- Fairness after release: owner 2 releases while `req`=1011. The next grant is 1000 (index 3, searched from `last`+1), not 0001.
- Reset mid-grant: `grant`=0100 and `reset` pulsed for one cycle with `req`=1010 held. All outputs are 0 after the reset edge. The first post-reset edge gives `grant`=0010.
